// File: rtl/alu_issue_queue.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_queue
// Purpose  : FIFO of ALU requests feeding a downstream combinational ALU, with
//            a registered, back-pressurable result stage.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [2:0]               in_opcode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_opcode,
  input  logic [31:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             PW   = $clog2(DEPTH);
  localparam int             CW   = PW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  logic [31:0]      r_mem_a   [DEPTH];
  logic [31:0]      r_mem_b   [DEPTH];
  logic [2:0]       r_mem_op  [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [31:0]      r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic w_not_empty;
  logic w_push;
  logic w_issue;

  assign w_not_empty = (r_count != '0);
  // Readiness depends only on occupancy, so a same-cycle pop never frees a slot early.
  assign in_ready    = (r_count < FULL);
  assign w_push      = in_valid && in_ready;
  assign w_issue     = w_not_empty && (!r_out_valid || out_ready);

  assign alu_a      = w_not_empty ? r_mem_a[r_rd_ptr]  : 32'd0;
  assign alu_b      = w_not_empty ? r_mem_b[r_rd_ptr]  : 32'd0;
  assign alu_opcode = w_not_empty ? r_mem_op[r_rd_ptr] : 3'b000;

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]   <= in_a;
      r_mem_b[r_wr_ptr]   <= in_b;
      r_mem_op[r_wr_ptr]  <= in_opcode;
      r_mem_tag[r_wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= 32'd0;
      r_out_tag    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_issue) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_out_valid  <= 1'b1;
        r_out_result <= alu_result;
        r_out_tag    <= r_mem_tag[r_rd_ptr];
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_issue);
    end
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, >= 2).
REQ-002 SHALL have parameter TAG_W, default 4, width of the request tag.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  queue can accept a request.
REQ-007 SHALL have port in_a  input  32  operand A.
REQ-008 SHALL have port in_b  input  32  operand B.
REQ-009 SHALL have port in_opcode  input  3  000 add, 001 sub, 010 unsigned A>B.
REQ-010 SHALL have port in_tag  input  TAG_W  requester tag.
REQ-011 SHALL have port alu_a  output  32  head operand A to the downstream combinational ALU.
REQ-012 SHALL have port alu_b  output  32  head operand B to the ALU.
REQ-013 SHALL have port alu_opcode  output  3  head opcode to the ALU.
REQ-014 SHALL have port alu_result  input  32  combinational ALU result for the presented operands.
REQ-015 SHALL have port out_valid  output  1  registered result present.
REQ-016 SHALL have port out_ready  input  1  consumer accepts result.
REQ-017 SHALL have port out_result  output  32  registered result.
REQ-018 SHALL have port out_tag  output  TAG_W  tag of the registered result.
REQ-019 SHALL have port count  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-020 SHALL hold requests in a DEPTH-entry FIFO of {a, b, opcode, tag}, with read/write pointers wrapping modulo DEPTH.
REQ-021 SHALL drive in_ready = (count < DEPTH), combinationally from state only, independent of in_valid and out_ready.
REQ-022 SHALL push on a rising edge when in_valid && in_ready; in_valid while in_ready is low is ignored (no overwrite).
REQ-023 SHALL drive alu_a/alu_b/alu_opcode from the head entry when count > 0; when count == 0, SHALL drive 0/0/3'b000.
REQ-024 SHALL define issue = (count > 0) && (!out_valid || out_ready).
REQ-025 On issue, SHALL load out_result <= alu_result and out_tag <= head tag, set out_valid, and pop the head, all in the same edge.
REQ-026 When out_valid && out_ready && !issue, SHALL clear out_valid; out_result/out_tag hold their last value.
REQ-027 When out_valid && !out_ready, SHALL hold out_valid, out_result and out_tag stable and SHALL NOT pop.
REQ-028 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged.
REQ-029 At count == DEPTH, a pop in the same cycle SHALL NOT enable a push; in_ready reasserts the following cycle.
REQ-030 Latency SHALL be: request accepted at edge N into an empty queue with the output idle -> on ALU ports after edge N; out_valid after edge N+1.
REQ-031 Sustained throughput SHALL be one result per cycle while out_ready is high and the queue is non-empty.
REQ-032 SHALL pass opcodes 011-111 through unfiltered; the result is whatever alu_result returns (0 for the standard ALU).
REQ-033 SHALL preserve FIFO order: results emerge in acceptance order with their original tags.

Reset
REQ-034 While rst is high, SHALL force count=0, pointers=0, out_valid=0, out_result=0 and out_tag=0 asynchronously.
REQ-035 Reset asserted mid-operation SHALL discard all queued entries and any pending result; no output appears after release until new pushes.
REQ-036 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-037 Single op: push A=5, B=3, op=001, tag=2 into an empty queue with out_ready=1 -> alu_a=5 one cycle later; out_valid=1, out_result=2, out_tag=2 the next cycle.
REQ-038 Backpressure: out_ready=0, push 5 requests (DEPTH=4; the first moves to the output register) -> in_ready=0 after the 5th push, count=4; release out_ready -> results in order, one per cycle.
REQ-039 Full boundary: count=4, in_valid=1, out_ready=1 in the same cycle -> no push that cycle, count=3, in_ready=1 next cycle.
REQ-040 Compare/undefined: op=010 with A=7, B=0xFFFFFFFF -> out_result=0; op=111 -> out_result=0, tag preserved.
REQ-041 Reset mid-stream with 3 queued and out_valid=1 -> immediately out_valid=0, count=0; after release no stale result appears.
REQ-042 Wrap: 20 back-to-back pushes with random out_ready and add ops -> all 20 results correct, in order, no loss or duplication.
